// File: rtl/array_24_client.sv
// Initiator for a single-port masked-write SRAM (RW0 port): zero-fills the array after reset,
// then converts a request stream into port cycles and queues read data behind a credit check.
module array_24_client #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 96,
   parameter int MASK_W     = 16,
   parameter int RESP_DEPTH = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [MASK_W-1:0] req_wmask,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              init_done,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic              RW0_en,
   output logic              RW0_wmode,
   output logic [MASK_W-1:0] RW0_wmask,
   output logic [DATA_W-1:0] RW0_wdata,
   input  logic [DATA_W-1:0] RW0_rdata
);

   localparam int PTR_W  = (RESP_DEPTH > 2) ? $clog2(RESP_DEPTH) : 1;
   localparam int OCC_W  = $clog2(RESP_DEPTH + 1);
   localparam int LAST_I = RESP_DEPTH - 1;
   localparam logic [PTR_W-1:0]  LAST_PTR  = LAST_I[PTR_W-1:0];
   localparam logic [OCC_W:0]    DEPTH_C   = RESP_DEPTH[OCC_W:0];
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] sweep;
   logic              done_q;
   logic              inflight;
   logic [OCC_W-1:0]  occ;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [DATA_W-1:0] queue [RESP_DEPTH];
   logic [OCC_W:0]    credit_used;
   logic              credit_ok;
   logic              accept;
   logic              push;
   logic              pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A read consumes a credit from issue until its data leaves the queue, so the
   // unconditional push one cycle after issue always finds a free entry.
   assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
   assign credit_ok   = credit_used < DEPTH_C;
   assign req_ready   = !reset && (state == RUN) && (req_write || credit_ok);
   assign accept      = req_valid && req_ready;
   assign push        = inflight;
   assign resp_valid  = !reset && (occ != '0);
   assign pop         = resp_valid && resp_ready;
   assign resp_rdata  = queue[head];
   assign init_done   = !reset && done_q;

   always_comb begin
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_addr  = req_addr;
      RW0_wmask = req_wmask;
      RW0_wdata = req_wdata;
      if (!reset) begin
         if (state == INIT) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = sweep;
            RW0_wmask = '1;
            RW0_wdata = '0;
         end else begin
            RW0_en    = accept;
            RW0_wmode = accept && req_write;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= INIT;
         sweep  <= '0;
         done_q <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               sweep <= sweep + 1'b1;
               if (sweep == LAST_ADDR) begin
                  state  <= RUN;
                  done_q <= 1'b1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   // issue stage -> capture stage: macro data is valid only the cycle after a read
   always_ff @(posedge clock) begin
      if (reset) begin
         inflight <= 1'b0;
         occ      <= '0;
         head     <= '0;
         tail     <= '0;
      end else begin
         inflight <= accept && !req_write;
         if (push) tail <= next_ptr(tail);
         if (pop)  head <= next_ptr(head);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) queue[tail] <= RW0_rdata;
   end

endmodule

// File: tb/tb_array_24_client.sv
// Randomized scoreboard bench for array_24_client with a behavioural RW0 macro model
// that returns garbage for never-written words and on cycles with no read.
module tb_array_24_client;

   localparam int AW     = 12;
   localparam int DW     = 96;
   localparam int MW     = 16;
   localparam int RD     = 3;
   localparam int NWORDS = 4096;
   localparam int GW     = DW / MW;

   logic          clock = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [MW-1:0] req_wmask;
   logic [DW-1:0] req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_rdata;
   logic          init_done;
   logic [AW-1:0] RW0_addr;
   logic          RW0_en;
   logic          RW0_wmode;
   logic [MW-1:0] RW0_wmask;
   logic [DW-1:0] RW0_wdata;
   logic [DW-1:0] RW0_rdata;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   logic [DW-1:0] shadow [NWORDS];
   logic [DW-1:0] exp_q [$];
   int            pop_cyc [$];

   logic [DW-1:0] sram [NWORDS];
   bit            seen [NWORDS];
   logic [DW-1:0] sram_q;

   always #5 clock = ~clock;

   array_24_client #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RESP_DEPTH(RD)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .init_done(init_done),
      .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
   );

   function automatic logic [DW-1:0] bitmask(input logic [MW-1:0] m);
      logic [DW-1:0] b = '0;
      for (int g = 0; g < MW; g++) b[g*GW +: GW] = {GW{m[g]}};
      return b;
   endfunction

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] r = old;
      for (int g = 0; g < MW; g++) if (m[g]) r[g*GW +: GW] = d[g*GW +: GW];
      return r;
   endfunction

   // Macro model: read-before-write, 1-cycle registered read, garbage outside valid cycles.
   assign RW0_rdata = sram_q;
   always @(posedge clock) begin
      if (RW0_en && RW0_wmode) begin
         sram[RW0_addr] <= (sram[RW0_addr] & ~bitmask(RW0_wmask)) | (RW0_wdata & bitmask(RW0_wmask));
         seen[RW0_addr] <= 1'b1;
      end
      if (RW0_en && !RW0_wmode)
         sram_q <= seen[RW0_addr] ? sram[RW0_addr] : {$urandom, $urandom, $urandom};
      else
         sram_q <= {$urandom, $urandom, $urandom};
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (!reset && resp_valid && resp_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL resp_unexpected: got %h, expected no response", resp_rdata);
            end else begin
               check("resp_data", resp_rdata, exp_q.pop_front());
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [MW-1:0] m,
                        input logic [DW-1:0] d, output int stalls);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wmask = m;
      req_wdata = d;
      stalls    = 0;
      forever begin
         @(negedge clock);
         if (req_ready) break;
         stalls++;
         @(posedge clock); #1;
         if (stalls >= 4) resp_ready = 1'b1;
         if (stalls > 200) begin
            tests++;
            failed++;
            $display("FAIL issue_timeout: req_ready stayed %b, expected 1", req_ready);
            req_valid = 1'b0;
            return;
         end
      end
      if (wr) shadow[a] = merge(shadow[a], d, m);
      else    exp_q.push_back(shadow[a]);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      resp_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clock); #1;
      end
      check("drain", DW'(exp_q.size()), '0);
   endtask

   task automatic fill_check();
      int            errs = 0;
      logic [AW-1:0] first = '1;
      for (int i = 0; i < NWORDS; i++) begin
         @(negedge clock);
         if (i == 0) first = RW0_addr;
         if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_wmask === '1 && RW0_wdata === '0 &&
               RW0_addr === AW'(i) && init_done === 1'b0 && req_ready === 1'b0))
            errs++;
      end
      check("fill_addr0", DW'(first), '0);
      check("fill_sweep", DW'(errs), '0);
      @(negedge clock);
      check("init_done", DW'(init_done), DW'(1));
      check("ready_after_fill", DW'(req_ready), DW'(1));
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
         check("rst_en", DW'(RW0_en), '0);
         check("rst_ready", DW'(req_ready), '0);
         check("rst_valid", DW'(resp_valid), '0);
         check("rst_init_done", DW'(init_done), '0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      exp_q.delete();
      for (int i = 0; i < NWORDS; i++) shadow[i] = '0;
      fill_check();
   endtask

   initial begin
      int s;
      int total;
      int gaps;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wmask  = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;

      do_reset();

      issue(1'b0, 12'hFFF, '0, '0, s);
      drain();

      // masked write, then read latency
      issue(1'b1, 12'h010, 16'h0001, '1, s);
      issue(1'b0, 12'h010, '0, '0, s);
      @(negedge clock);
      check("lat_t1", DW'(resp_valid), '0);
      @(negedge clock);
      check("lat_t2", DW'(resp_valid), DW'(1));
      @(posedge clock); #1;
      drain();

      // streaming reads
      for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), '1, DW'(i), s);
      pop_cyc.delete();
      total = 0;
      for (int i = 0; i < 16; i++) begin
         issue(1'b0, AW'(i), '0, '0, s);
         total += s;
      end
      drain();
      gaps = 0;
      for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] != 1) gaps++;
      check("stream_stall", DW'(total), '0);
      check("stream_count", DW'(pop_cyc.size()), DW'(16));
      check("stream_gap", DW'(gaps), '0);

      // backpressure
      resp_ready = 1'b0;
      total = 0;
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, AW'(i), '0, '0, s);
         total += s;
      end
      check("bp_accept3", DW'(total), '0);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h003;
      @(negedge clock);
      check("bp_block", DW'(req_ready), '0);
      check("bp_resp_valid", DW'(resp_valid), DW'(1));
      @(posedge clock); #1;
      @(negedge clock);
      check("bp_block2", DW'(req_ready), '0);
      @(posedge clock); #1;
      issue(1'b1, 12'h100, '1, {3{32'hDEADBEEF}}, s);
      check("bp_write_ready", DW'(s), '0);
      resp_ready = 1'b1;
      issue(1'b0, 12'h003, '0, '0, s);
      issue(1'b0, 12'h004, '0, '0, s);
      drain();

      // read followed next cycle by a write to the same address
      issue(1'b1, 12'h020, '1, DW'(12'hAAA), s);
      drain();
      issue(1'b0, 12'h020, '0, '0, s);
      issue(1'b1, 12'h020, '1, DW'(12'h555), s);
      issue(1'b0, 12'h020, '0, '0, s);
      drain();

      // randomized traffic over a small address window
      for (int n = 0; n < 300; n++) begin
         resp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clock); #1;
         end
         issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), MW'($urandom),
               {$urandom, $urandom, $urandom}, s);
      end
      drain();

      // reset with two responses queued and one read in flight
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), '0, '0, s);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clock);
      check("midrst_valid", DW'(resp_valid), '0);
      check("midrst_en", DW'(RW0_en), '0);
      @(posedge clock); #1;
      @(negedge clock);
      check("midrst_valid2", DW'(resp_valid), '0);
      @(posedge clock); #1;
      do_reset();
      resp_ready = 1'b1;
      issue(1'b0, 12'h010, '0, '0, s);
      issue(1'b0, 12'h020, '0, '0, s);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
